// File: rtl/fifo_drain_dma.sv
// fifo_drain_dma: drains a fixed number of words from an upstream FIFO and
// writes them to consecutive word addresses on a simple req/ack write bus.
// One word moves per FETCH/WRITE pair. The optional abort feature is compiled
// in with the macro FIFO_DRAIN_ABORT_EN, which adds the Abort/Aborted ports.
module fifo_drain_dma #(
    parameter int C_DWIDTH = 32,
    parameter int C_LWIDTH = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [31:0]         Dst_Addr,
    input  logic [C_LWIDTH-1:0] Length,
    output logic                FIFO_Read,
    input  logic [C_DWIDTH-1:0] FIFO_Data,
    input  logic                FIFO_Empty,
    output logic                Bus_Req,
    output logic [31:0]         Bus_Addr,
    output logic [C_DWIDTH-1:0] Bus_Data,
    input  logic                Bus_Ack,
    output logic                Busy,
    output logic                Done,
    output logic [C_LWIDTH-1:0] Words_Left
`ifdef FIFO_DRAIN_ABORT_EN
    ,
    input  logic                Abort,
    output logic                Aborted
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_WRITE  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [31:0]         C_ADDR_STEP = 32'd4;
    localparam logic [C_LWIDTH-1:0] C_ONE_WORD  = C_LWIDTH'(1);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_bus_addr;
    logic [C_DWIDTH-1:0] r_bus_data;
    logic [C_LWIDTH-1:0] r_words_left;
    logic                w_abort;
    logic                w_accept;
    logic                w_pop;
    logic                w_wr_ack;

`ifdef FIFO_DRAIN_ABORT_EN
    logic                r_aborted;
    assign w_abort = Abort && ((r_state == S_FETCH) || (r_state == S_WRITE));
    assign Aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    // Handshake qualifiers: accepted start, actual FIFO pop, counted bus write.
    // An abort suppresses the pop and discards a same-cycle acknowledge.
    always_comb begin
        w_accept = (r_state == S_IDLE) && Start && (Length != '0);
        w_pop    = (r_state == S_FETCH) && !FIFO_Empty && !w_abort;
        w_wr_ack = (r_state == S_WRITE) && Bus_Ack && !w_abort;
    end

    // Next-state decode and Moore/handshake outputs.
    always_comb begin
        w_next    = r_state;
        FIFO_Read = w_pop;
        Bus_Req   = (r_state == S_WRITE);
        Busy      = (r_state != S_IDLE);
        Done      = (r_state == S_FINISH);
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = (Length == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_abort) begin
                    w_next = S_FINISH;
                end else if (!FIFO_Empty) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_abort) begin
                    w_next = S_FINISH;
                end else if (Bus_Ack) begin
                    w_next = (r_words_left == C_ONE_WORD) ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address, data and word-count registers; address wraps modulo 2^32.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bus_addr   <= '0;
            r_bus_data   <= '0;
            r_words_left <= '0;
        end else begin
            if (w_accept) begin
                r_bus_addr   <= Dst_Addr;
                r_words_left <= Length;
            end
            if (w_pop) begin
                r_bus_data <= FIFO_Data;
            end
            if (w_wr_ack) begin
                r_bus_addr   <= r_bus_addr + C_ADDR_STEP;
                r_words_left <= r_words_left - C_ONE_WORD;
            end
        end
    end

`ifdef FIFO_DRAIN_ABORT_EN
    // Aborted is set on the edge into FINISH and cleared on the edge out,
    // so it pulses together with Done.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_aborted <= 1'b0;
        end else if (r_state == S_FINISH) begin
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_aborted <= 1'b1;
        end
    end
`endif

    assign Bus_Addr   = r_bus_addr;
    assign Bus_Data   = r_bus_data;
    assign Words_Left = r_words_left;

endmodule

// File: tb/tb_fifo_drain_dma.sv
// Testbench for fifo_drain_dma: table of directed transfers plus hand-written
// reset and (when FIFO_DRAIN_ABORT_EN is defined) abort sequences.
module tb_fifo_drain_dma;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic [31:0]   Dst_Addr;
    logic [LW-1:0] Length;
    logic          FIFO_Read;
    logic [DW-1:0] FIFO_Data;
    logic          FIFO_Empty;
    logic          Bus_Req;
    logic [31:0]   Bus_Addr;
    logic [DW-1:0] Bus_Data;
    logic          Bus_Ack;
    logic          Busy;
    logic          Done;
    logic [LW-1:0] Words_Left;
`ifdef FIFO_DRAIN_ABORT_EN
    logic          Abort;
    logic          Aborted;
`endif

    fifo_drain_dma #(.C_DWIDTH(DW), .C_LWIDTH(LW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dst_Addr(Dst_Addr),
        .Length(Length), .FIFO_Read(FIFO_Read), .FIFO_Data(FIFO_Data),
        .FIFO_Empty(FIFO_Empty), .Bus_Req(Bus_Req), .Bus_Addr(Bus_Addr),
        .Bus_Data(Bus_Data), .Bus_Ack(Bus_Ack), .Busy(Busy), .Done(Done),
        .Words_Left(Words_Left)
`ifdef FIFO_DRAIN_ABORT_EN
        , .Abort(Abort), .Aborted(Aborted)
`endif
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Upstream FIFO model and bus responder state
    logic [DW-1:0] fq[$];
    logic          force_empty = 1'b0;
    logic          ack_en      = 1'b1;
    int            ack_delay   = 0;
    int            wait_cnt    = 0;

    assign Bus_Ack = ack_en && Bus_Req && (wait_cnt >= ack_delay);

    // Observation state
    int            cyc = 0;
    int            start_cyc, done_cyc, done_cnt, pops, bad_read, overlap, stab_err;
    logic          done_seen;
    logic          pop_pend   = 1'b0;
    logic          stall_prev = 1'b0;
    logic [31:0]   prev_addr;
    logic [DW-1:0] prev_data;
    logic [31:0]   wa[$];
    logic [DW-1:0] wd[$];

    typedef struct {
        logic [LW-1:0]      len;
        logic [31:0]        dst;
        int                 ackd;
        int                 fill;
        int                 mid;
        int                 lat;
        logic [2:0][31:0]   a;
        logic [2:0][31:0]   d;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        FIFO_Empty = force_empty || (fq.size() == 0);
        FIFO_Data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic clear_obs();
        done_seen = 1'b0; done_cnt = 0; pops = 0; bad_read = 0;
        overlap = 0; stab_err = 0; start_cyc = 0; done_cyc = -1000;
        wa.delete(); wd.delete();
    endtask

    // One clock cycle: observe mid-cycle, then apply FIFO pop and ack timing
    // just after the rising edge.
    task automatic step();
        @(negedge Clk);
        pop_pend = FIFO_Read && !FIFO_Empty;
        if (pop_pend) pops++;
        if (FIFO_Read && FIFO_Empty) bad_read++;
        if (FIFO_Read && Bus_Req) overlap++;
        if (Start && !Busy && !Reset) start_cyc = cyc;
        if (Done) begin done_seen = 1'b1; done_cyc = cyc; done_cnt++; end
        if (Bus_Req && stall_prev && (Bus_Addr !== prev_addr || Bus_Data !== prev_data))
            stab_err++;
        if (Bus_Req && Bus_Ack) begin wa.push_back(Bus_Addr); wd.push_back(Bus_Data); end
        stall_prev = Bus_Req && !Bus_Ack;
        prev_addr  = Bus_Addr;
        prev_data  = Bus_Data;
        @(posedge Clk);
        #1;
        cyc++;
        if (pop_pend) fq.delete(0);
        wait_cnt = stall_prev ? wait_cnt + 1 : 0;
        refresh_fifo();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        fq.delete();
        for (int i = 0; i < int'(v.len) && i < 3; i++) fq.push_back(v.d[i]);
        force_empty = (v.fill > 0);
        ack_en = 1'b1;
        ack_delay = v.ackd;
        clear_obs();
        refresh_fifo();
        Dst_Addr = v.dst; Length = v.len; Start = 1'b1;
        step();
        Start = 1'b0; Dst_Addr = 32'hDEAD_0000; Length = 16'd7;
        for (int k = 1; k <= 200 && !done_seen; k++) begin
            step();
            if (k == v.fill) begin force_empty = 1'b0; refresh_fifo(); end
            Start = (v.mid != 0) && (k == v.mid);
        end
        Start = 1'b0;
        step();
        step();
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(v.lat));
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_writes"}, 32'(wa.size()), 32'(v.len));
        for (int i = 0; i < int'(v.len) && i < 3; i++) begin
            if (i < wa.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wa[i], v.a[i]);
                chk($sformatf("%s_data%0d", tag, i), wd[i], v.d[i]);
            end
        end
        chk({tag, "_pops"}, 32'(pops), 32'(v.len));
        chk({tag, "_read_while_empty"}, 32'(bad_read), 32'd0);
        chk({tag, "_read_and_req"}, 32'(overlap), 32'd0);
        chk({tag, "_bus_stable"}, 32'(stab_err), 32'd0);
        chk({tag, "_words_left"}, 32'(Words_Left), 32'd0);
        chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        //                len     dst           ackd fill mid lat  addresses (a[2],a[1],a[0])                  data (d[2],d[1],d[0])
        vt[0] = '{16'd3, 32'h0000_1000, 0, 0, 0, 7,  {32'h0000_1008, 32'h0000_1004, 32'h0000_1000}, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001}};
        vt[1] = '{16'd2, 32'h0000_2000, 0, 5, 0, 10, {32'h0,         32'h0000_2004, 32'h0000_2000}, {32'h0,         32'hB000_0002, 32'hB000_0001}};
        vt[2] = '{16'd2, 32'h0000_3000, 4, 0, 0, 13, {32'h0,         32'h0000_3004, 32'h0000_3000}, {32'h0,         32'h1234_5678, 32'h8765_4321}};
        vt[3] = '{16'd3, 32'hFFFF_FFF8, 0, 0, 0, 7,  {32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}, {32'hC000_0003, 32'hC000_0002, 32'hC000_0001}};
        vt[4] = '{16'd0, 32'h0000_4000, 0, 0, 0, 1,  {32'h0,         32'h0,         32'h0},         {32'h0,         32'h0,         32'h0}};
        vt[5] = '{16'd1, 32'h0000_5000, 1, 2, 0, 6,  {32'h0,         32'h0,         32'h0000_5000}, {32'h0,         32'h0,         32'hFFFF_0000}};
        vt[6] = '{16'd2, 32'h0000_6000, 0, 0, 2, 5,  {32'h0,         32'h0000_6004, 32'h0000_6000}, {32'h0,         32'h5555_AAAA, 32'hAAAA_5555}};

        Reset = 1'b1; Start = 1'b0; Dst_Addr = '0; Length = '0;
`ifdef FIFO_DRAIN_ABORT_EN
        Abort = 1'b0;
`endif
        clear_obs();
        refresh_fifo();
        step(); step(); step();
        chk("rst_fifo_read", 32'(FIFO_Read), 32'd0);
        chk("rst_bus_req", 32'(Bus_Req), 32'd0);
        chk("rst_bus_addr", Bus_Addr, 32'd0);
        chk("rst_bus_data", Bus_Data, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_words_left", 32'(Words_Left), 32'd0);
`ifdef FIFO_DRAIN_ABORT_EN
        chk("rst_aborted", 32'(Aborted), 32'd0);
`endif
        Reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

        // Reset while a write is pending, together with Start and Bus_Ack
        fq.delete(); fq.push_back(32'hC0DE_0001); fq.push_back(32'hC0DE_0002);
        force_empty = 1'b0; ack_en = 1'b0; ack_delay = 0;
        clear_obs(); refresh_fifo();
        Dst_Addr = 32'h0000_8000; Length = 16'd2; Start = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 0; k < 20 && !Bus_Req; k++) step();
        chk("rw_bus_req", 32'(Bus_Req), 32'd1);
        chk("rw_words_left", 32'(Words_Left), 32'd2);
        chk("rw_bus_addr", Bus_Addr, 32'h0000_8000);
        chk("rw_bus_data", Bus_Data, 32'hC0DE_0001);
        Reset = 1'b1; Start = 1'b1; Length = 16'd5; ack_en = 1'b1;
        step();
        chk("rw_rst_fifo_read", 32'(FIFO_Read), 32'd0);
        chk("rw_rst_bus_req", 32'(Bus_Req), 32'd0);
        chk("rw_rst_bus_addr", Bus_Addr, 32'd0);
        chk("rw_rst_bus_data", Bus_Data, 32'd0);
        chk("rw_rst_busy", 32'(Busy), 32'd0);
        chk("rw_rst_done", 32'(Done), 32'd0);
        chk("rw_rst_words_left", 32'(Words_Left), 32'd0);
        Reset = 1'b0; Start = 1'b0;
        step();
        chk("rw_idle_after", 32'(Busy), 32'd0);

`ifdef FIFO_DRAIN_ABORT_EN
        // Abort in WRITE with Bus_Ack high: word not counted, Done+Aborted pulse
        fq.delete(); fq.push_back(32'h0A0A_0001); fq.push_back(32'h0A0A_0002); fq.push_back(32'h0A0A_0003);
        force_empty = 1'b0; ack_en = 1'b1; ack_delay = 0;
        clear_obs(); refresh_fifo();
        Dst_Addr = 32'h0000_7000; Length = 16'd3; Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        chk("ab_in_write", 32'(Bus_Req), 32'd1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("ab_done", 32'(Done), 32'd1);
        chk("ab_aborted", 32'(Aborted), 32'd1);
        chk("ab_words_left", 32'(Words_Left), 32'd3);
        chk("ab_bus_addr", Bus_Addr, 32'h0000_7000);
        chk("ab_bus_req", 32'(Bus_Req), 32'd0);
        step();
        chk("ab_idle", 32'(Busy), 32'd0);
        chk("ab_aborted_clear", 32'(Aborted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_drain_dma.md
FIFO_DRAIN_DMA -- requirements
Module: fifo_drain_dma

Interface
REQ-001 SHALL have parameter C_DWIDTH, default 32, data word width.
REQ-002 SHALL have parameter C_LWIDTH, default 16, transfer-length counter width.
REQ-003 SHALL have port Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin transfer; sampled only in IDLE.
REQ-006 SHALL have port Dst_Addr  input  32  byte address of first word, latched on accepted Start.
REQ-007 SHALL have port Length  input  C_LWIDTH  word count, latched on accepted Start.
REQ-008 SHALL have port FIFO_Read  output  1  pop request to upstream FIFO.
REQ-009 SHALL have port FIFO_Data  input  C_DWIDTH  FIFO head word, valid in the cycle FIFO_Read=1 and FIFO_Empty=0.
REQ-010 SHALL have port FIFO_Empty  input  1  upstream FIFO empty flag.
REQ-011 SHALL have port Bus_Req  output  1  bus write request.
REQ-012 SHALL have port Bus_Addr  output  32  bus write address.
REQ-013 SHALL have port Bus_Data  output  C_DWIDTH  bus write data.
REQ-014 SHALL have port Bus_Ack  input  1  bus write accepted; meaningful only while Bus_Req=1.
REQ-015 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port Words_Left  output  C_LWIDTH  words remaining in current transfer.

Function
REQ-018 SHALL implement states IDLE, FETCH, WRITE, FINISH.
REQ-019 IDLE: Start=1 and Length!=0 SHALL latch Dst_Addr into Bus_Addr, Length into Words_Left, and go to FETCH next cycle.
REQ-020 IDLE: Start=1 and Length=0 SHALL go directly to FINISH; no FIFO pop, no bus request.
REQ-021 FETCH: FIFO_Read SHALL equal !FIFO_Empty (combinational); never asserted while FIFO_Empty=1.
REQ-022 FETCH with FIFO_Empty=0: FIFO_Data SHALL be registered into Bus_Data and state SHALL go to WRITE; exactly one word popped.
REQ-023 FETCH with FIFO_Empty=1: state SHALL remain FETCH indefinitely (no timeout).
REQ-024 WRITE: Bus_Req SHALL be 1; Bus_Addr and Bus_Data SHALL be held stable until the cycle Bus_Ack=1.
REQ-025 WRITE with Bus_Ack=1: Bus_Addr SHALL increment by 4 (modulo 2^32, wrap 0xFFFFFFFC->0x00000000), Words_Left SHALL decrement by 1, Bus_Req SHALL drop next cycle.
REQ-026 After Ack, Words_Left reaching 0 SHALL select FINISH, otherwise FETCH.
REQ-027 FINISH: Done SHALL be 1 for exactly that cycle; state SHALL return to IDLE next cycle.
REQ-028 Start asserted while Busy=1 SHALL be ignored with no side effect.
REQ-029 Minimum throughput SHALL be 2 cycles per word (FETCH 1, WRITE 1 with Bus_Ack already high).
REQ-030 FIFO_Read and Bus_Req SHALL never be 1 in the same cycle.

Reset
REQ-031 Reset=1 SHALL force IDLE on the next edge, from any state, including mid-WRITE with Bus_Req high.
REQ-032 Reset values: FIFO_Read=0, Bus_Req=0, Bus_Addr=0, Bus_Data=0, Busy=0, Done=0, Words_Left=0.
REQ-033 Reset SHALL take priority over Start, Bus_Ack and FIFO_Empty in the same cycle.

Configuration
REQ-034 Macro FIFO_DRAIN_ABORT_EN defined SHALL add input port Abort (1 bit) and output port Aborted (1 bit, reset 0).
REQ-035 With FIFO_DRAIN_ABORT_EN: Abort=1 in FETCH or WRITE SHALL go to FINISH next cycle, drop Bus_Req/FIFO_Read, leave remaining words unpopped; Aborted SHALL pulse with Done; Abort has priority over Bus_Ack in the same cycle (word not counted).
REQ-036 Without FIFO_DRAIN_ABORT_EN: ports Abort and Aborted SHALL not exist; transfers run to completion or Reset.

Verification
REQ-037 Start, Dst_Addr=0x1000, Length=3, FIFO preloaded 3 words, Bus_Ack tied 1 -> writes to 0x1000/0x1004/0x1008 in FIFO order, Done pulse 7 cycles after Start, Words_Left=0.
REQ-038 Length=2, FIFO empty for 5 cycles then filled -> FIFO_Read stays 0 while empty, state holds FETCH, transfer completes normally.
REQ-039 Bus_Ack delayed 4 cycles per word -> Bus_Addr/Bus_Data stable throughout, one pop per word, no extra FIFO_Read.
REQ-040 Dst_Addr=0xFFFFFFF8, Length=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-041 Length=0 -> Done pulse in cycle after Start, no FIFO_Read, no Bus_Req; Start pulsed mid-transfer -> ignored.
REQ-042 Reset asserted in WRITE with Bus_Req=1 -> next cycle all outputs at reset values; with FIFO_DRAIN_ABORT_EN, Abort in WRITE with Bus_Ack=1 -> Done and Aborted pulse, Words_Left unchanged.
